// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// issues datapath strobes and mux selects, guards memory waits with a watchdog, counts retirements.
module mc_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             instr_zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    input  logic             zero,
    output logic             im_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             reg_we,
    output logic [1:0]       wa_sel,
    output logic [1:0]       wd_sel,
    output logic             dm_re,
    output logic             dm_we,
    output logic [2:0]       alu_op,
    output logic             alu_b_imm,
    output logic [1:0]       ext_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             err,
    output logic [2:0]       state
);

    // Handshake: a request (im_req in FETCH, dm_re/dm_we in MEM) is held until the matching
    // ready is seen high in the same cycle; a ready outside its request state is ignored.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     cur;
    logic [5:0] op_q;
    logic [5:0] func_q;
    logic [7:0] wait_cnt;

    logic supported;
    logic is_addu, is_subu, is_jr, is_rtype, is_jal, is_beq;
    logic is_ori, is_lui, is_lw, is_sw, is_nop;
    logic retire_c;

    always_comb begin
        supported = 1'b0;
        case (op)
            OP_RTYPE: supported = (func == FN_ADDU) || (func == FN_SUBU) || (func == FN_JR);
            OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: supported = 1'b1;
            default:  supported = 1'b0;
        endcase
    end

    // A nop or unsupported word is latched as op/func 0/0, which decodes to no class at all.
    assign is_addu  = (op_q == OP_RTYPE) && (func_q == FN_ADDU);
    assign is_subu  = (op_q == OP_RTYPE) && (func_q == FN_SUBU);
    assign is_jr    = (op_q == OP_RTYPE) && (func_q == FN_JR);
    assign is_rtype = is_addu || is_subu;
    assign is_jal   = (op_q == OP_JAL);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_ori   = (op_q == OP_ORI);
    assign is_lui   = (op_q == OP_LUI);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_nop   = !(is_rtype || is_jr || is_jal || is_beq || is_ori || is_lui || is_lw || is_sw);

    always_comb begin
        retire_c = 1'b0;
        case (cur)
            S_DECODE: retire_c = is_nop || is_jal || is_jr;
            S_EXEC:   retire_c = is_beq;
            S_MEM:    retire_c = is_sw && dm_ready;
            S_WB:     retire_c = 1'b1;
            default:  retire_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= S_FETCH;
            op_q      <= 6'd0;
            func_q    <= 6'd0;
            wait_cnt  <= 8'd0;
            err       <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if (retire_c) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            case (cur)
                S_FETCH: begin
                    if (im_ready) begin
                        wait_cnt <= 8'd0;
                        cur      <= S_DECODE;
                        if (instr_zero || !supported) begin
                            op_q   <= 6'd0;
                            func_q <= 6'd0;
                        end else begin
                            op_q   <= op;
                            func_q <= func;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 8'd0;
                        err      <= 1'b1;
                        cur      <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (is_nop || is_jal || is_jr) begin
                        cur <= S_FETCH;
                    end else if (is_lui) begin
                        cur <= S_WB;
                    end else begin
                        cur <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        cur <= S_MEM;
                    end else if (is_beq) begin
                        cur <= S_FETCH;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dm_ready) begin
                        wait_cnt <= 8'd0;
                        cur      <= is_lw ? S_WB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 8'd0;
                        err      <= 1'b1;
                        cur      <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_FETCH;
            endcase
        end
    end

    assign state = cur;

    // Outputs decode the registered state and latched instruction; asserting reset forces them quiet.
    always_comb begin
        im_req    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        npc_sel   = 2'b00;
        reg_we    = 1'b0;
        wa_sel    = 2'b00;
        wd_sel    = 2'b00;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        alu_op    = 3'b000;
        alu_b_imm = 1'b0;
        ext_sel   = 2'b00;
        retire    = 1'b0;
        if (!reset) begin
            retire = retire_c;
            case (cur)
                S_FETCH: begin
                    im_req = 1'b1;
                    ir_we  = im_ready;
                    pc_we  = im_ready;
                end
                S_DECODE: begin
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        wa_sel  = 2'b10;
                        wd_sel  = 2'b11;
                        pc_we   = 1'b1;
                        npc_sel = 2'b10;
                    end else if (is_jr) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'b11;
                    end
                end
                S_EXEC: begin
                    if (is_subu) begin
                        alu_op = 3'b001;
                    end else if (is_ori) begin
                        alu_op    = 3'b010;
                        alu_b_imm = 1'b1;
                        ext_sel   = 2'b00;
                    end else if (is_lw || is_sw) begin
                        alu_op    = 3'b000;
                        alu_b_imm = 1'b1;
                        ext_sel   = 2'b01;
                    end else if (is_beq) begin
                        alu_op  = 3'b001;
                        pc_we   = zero;
                        npc_sel = 2'b01;
                    end
                end
                S_MEM: begin
                    dm_re = is_lw;
                    dm_we = is_sw;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    if (is_rtype) begin
                        wa_sel = 2'b01;
                        wd_sel = 2'b00;
                    end else if (is_lw) begin
                        wd_sel = 2'b01;
                    end else if (is_lui) begin
                        wd_sel = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each instruction is driven through the FSM, per-cycle strobes are
// captured, and cycle count / retire count are checked against an expected-result queue.
module tb_mc_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       op = 6'd0;
    logic [5:0]       func = 6'd0;
    logic             instr_zero = 1'b0;
    logic             im_ready = 1'b0;
    logic             dm_ready = 1'b0;
    logic             zero = 1'b0;
    logic             im_req, ir_we, pc_we, reg_we, dm_re, dm_we, alu_b_imm, retire, err;
    logic [1:0]       npc_sel, wa_sel, wd_sel, ext_sel;
    logic [2:0]       alu_op, state;
    logic [CNT_W-1:0] instr_cnt;

    always #5 clk = ~clk;

    mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .instr_zero(instr_zero),
        .im_ready(im_ready), .dm_ready(dm_ready), .zero(zero),
        .im_req(im_req), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
        .reg_we(reg_we), .wa_sel(wa_sel), .wd_sel(wd_sel), .dm_re(dm_re), .dm_we(dm_we),
        .alu_op(alu_op), .alu_b_imm(alu_b_imm), .ext_sel(ext_sel), .retire(retire),
        .instr_cnt(instr_cnt), .err(err), .state(state)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]      exp_q[$];
    logic [CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    logic [31:0] trace;
    int          cyc, n_reg_we, n_pcw, n_re, n_we;
    logic [1:0]  cap_wa, cap_wd, cap_npc, cap_ext;
    logic [2:0]  cap_rw_st, cap_pcw_st, cap_alu;
    logic        cap_bimm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one instruction from FETCH to retirement; called just after a rising edge in FETCH.
    task automatic run(input string name, input logic [5:0] op_i, input logic [5:0] func_i,
                       input logic nop_word, input logic zf, input int dm_wait, input int cycles);
        int waited = 0;
        bit done = 1'b0;
        exp_q.push_back(32'(cycles));
        exp_cnt = exp_cnt + 1'b1;
        cnt_q.push_back(exp_cnt);
        trace = 32'd0; cyc = 0; n_reg_we = 0; n_pcw = 0; n_re = 0; n_we = 0;
        cap_wa = 2'b11; cap_wd = 2'b11; cap_npc = 2'b00; cap_ext = 2'b11;
        cap_rw_st = 3'd7; cap_pcw_st = 3'd7; cap_alu = 3'b111; cap_bimm = 1'b0;
        zero = zf;
        for (int c = 0; c < 40 && !done; c++) begin
            if (state == 3'd0) begin
                op = op_i; func = func_i; instr_zero = nop_word; im_ready = 1'b1;
            end else begin
                op = 6'($urandom_range(0, 63));
                func = 6'($urandom_range(0, 63));
                instr_zero = 1'($urandom_range(0, 1));
                im_ready = 1'($urandom_range(0, 1));
            end
            if (state == 3'd3) begin
                dm_ready = (waited >= dm_wait);
                waited++;
            end else begin
                dm_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            trace = {trace[28:0], state};
            if (state == 3'd0) begin
                chk({name, "_fetch_ir_we"}, ir_we, 1'b1);
                chk({name, "_fetch_pc_we"}, {pc_we, npc_sel}, 3'b100);
            end
            if (reg_we) begin
                n_reg_we++; cap_wa = wa_sel; cap_wd = wd_sel; cap_rw_st = state;
            end
            if (pc_we && state != 3'd0) begin
                n_pcw++; cap_npc = npc_sel; cap_pcw_st = state;
            end
            if (dm_re) n_re++;
            if (dm_we) n_we++;
            if (state == 3'd2) begin
                cap_alu = alu_op; cap_bimm = alu_b_imm; cap_ext = ext_sel;
            end
            if (retire) begin
                done = 1'b1;
                cyc = c + 1;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_retired"}, done, 1'b1);
        chk({name, "_cycles"}, cyc, exp_q.pop_front());
        chk({name, "_cnt"}, instr_cnt, cnt_q.pop_front());
        chk({name, "_back_to_fetch"}, state, 3'd0);
        chk({name, "_err"}, err, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 3'd0);
        chk("rst_cnt", instr_cnt, 4'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_strobes", {ir_we, pc_we, reg_we, dm_re, dm_we, retire}, 6'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_im_req", im_req, 1'b1);

        run("addu", 6'h00, 6'h21, 1'b0, 1'b0, 0, 4);
        chk("addu_trace", trace, 32'o124);
        chk("addu_reg_we", {n_reg_we[3:0], cap_rw_st, cap_wa, cap_wd}, {4'd1, 3'd4, 2'b01, 2'b00});
        chk("addu_alu", cap_alu, 3'b000);

        run("subu", 6'h00, 6'h23, 1'b0, 1'b0, 0, 4);
        chk("subu_alu", {cap_alu, cap_bimm}, {3'b001, 1'b0});
        chk("subu_wb", {cap_rw_st, cap_wa, cap_wd}, {3'd4, 2'b01, 2'b00});

        run("ori", 6'h0d, 6'h15, 1'b0, 1'b0, 0, 4);
        chk("ori_alu", {cap_alu, cap_bimm, cap_ext}, {3'b010, 1'b1, 2'b00});
        chk("ori_wb", {cap_rw_st, cap_wa, cap_wd}, {3'd4, 2'b00, 2'b00});

        run("lw", 6'h23, 6'h00, 1'b0, 1'b0, 3, 8);
        chk("lw_trace", trace, 32'o1233334);
        chk("lw_dm_re_cycles", n_re, 4);
        chk("lw_alu", {cap_alu, cap_bimm, cap_ext}, {3'b000, 1'b1, 2'b01});
        chk("lw_wb", {cap_rw_st, cap_wa, cap_wd}, {3'd4, 2'b00, 2'b01});

        run("sw", 6'h2b, 6'h00, 1'b0, 1'b0, 1, 5);
        chk("sw_trace", trace, 32'o1233);
        chk("sw_dm", {n_we[3:0], n_re[3:0], n_reg_we[3:0]}, {4'd2, 4'd0, 4'd0});

        run("beq_taken", 6'h04, 6'h00, 1'b0, 1'b1, 0, 3);
        chk("beq_taken_trace", trace, 32'o12);
        chk("beq_taken_pc", {n_pcw[3:0], cap_pcw_st, cap_npc}, {4'd1, 3'd2, 2'b01});
        chk("beq_alu", cap_alu, 3'b001);

        run("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0, 0, 3);
        chk("beq_nt_pc", n_pcw, 0);

        run("jal", 6'h03, 6'h00, 1'b0, 1'b0, 0, 2);
        chk("jal_reg", {cap_rw_st, cap_wa, cap_wd}, {3'd1, 2'b10, 2'b11});
        chk("jal_pc", {n_pcw[3:0], cap_pcw_st, cap_npc}, {4'd1, 3'd1, 2'b10});

        run("jr", 6'h00, 6'h08, 1'b0, 1'b0, 0, 2);
        chk("jr_pc", {n_pcw[3:0], cap_npc, n_reg_we[3:0]}, {4'd1, 2'b11, 4'd0});

        run("nop_word", 6'h23, 6'h00, 1'b1, 1'b0, 0, 2);
        chk("nop_no_writes", {n_pcw[3:0], n_reg_we[3:0], n_re[3:0], n_we[3:0]}, 16'd0);

        run("lui", 6'h0f, 6'h00, 1'b0, 1'b0, 0, 3);
        chk("lui_trace", trace, 32'o14);
        chk("lui_wb", {cap_rw_st, cap_wa, cap_wd}, {3'd4, 2'b00, 2'b10});

        run("unsupported", 6'h08, 6'h00, 1'b0, 1'b0, 0, 2);
        chk("unsup_no_writes", {n_pcw[3:0], n_reg_we[3:0]}, 8'd0);

        // Watchdog: fetch never answered
        im_ready = 1'b0;
        repeat (WAIT_MAX - 1) begin
            @(posedge clk);
            #1;
        end
        chk("wd_before_limit", {state, err}, {3'd0, 1'b0});
        @(posedge clk);
        #1;
        chk("wd_halt", {state, err, im_req}, {3'd7, 1'b1, 1'b0});
        im_ready = 1'b1;
        dm_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("halt_sticky", {state, err, retire}, {3'd7, 1'b1, 1'b0});
        chk("halt_cnt", instr_cnt, exp_cnt);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", {state, err}, {3'd0, 1'b0});
        chk("async_rst_cnt", instr_cnt, 4'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Counter wrap
        for (int i = 0; i < 17; i++) begin
            run("nop_wrap", 6'h00, 6'h00, 1'b1, 1'b0, 0, 2);
        end
        chk("wrap_cnt", instr_cnt, 4'd1);

        // Reset in the middle of a store's memory wait
        op = 6'h2b; func = 6'h00; instr_zero = 1'b0; im_ready = 1'b1; dm_ready = 1'b0;
        for (int c = 0; c < 10 && state != 3'd3; c++) begin
            @(posedge clk);
            #1;
        end
        chk("sw_in_mem", state, 3'd3);
        @(negedge clk);
        chk("sw_dm_we", dm_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_dm_we", {dm_we, retire}, 2'b00);
        chk("mid_rst_cnt", instr_cnt, 4'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_cnt", {state, instr_cnt}, {3'd0, 4'd0});
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
